// File: rtl/nna_pkg.sv
// Shared types for the accelerator's streaming read path.
package nna_pkg;

    // Read sequencer command states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } rd_state_t;

    // Slots available downstream of the memory: FIFO entries plus the in-flight read.
    localparam int unsigned STREAM_CREDITS = 2;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry register FIFO carrying a data word and a last flag.
// Slot 0 is always the head, so the presented word only changes on a pop
// or on a push into an empty FIFO.
module stream_fifo2 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_push_last,
    input  logic             i_pop,
    output logic [1:0]       o_count,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_last
);

    logic [WIDTH-1:0] r_data0;
    logic [WIDTH-1:0] r_data1;
    logic             r_last0;
    logic             r_last1;
    logic [1:0]       r_count;

    // Storage and occupancy update; callers never push when full without popping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data0 <= '0;
            r_data1 <= '0;
            r_last0 <= 1'b0;
            r_last1 <= 1'b0;
            r_count <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_data0 <= i_push_data;
                        r_last0 <= i_push_last;
                    end else begin
                        r_data1 <= i_push_data;
                        r_last1 <= i_push_last;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_last0 <= r_last1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word lands behind whatever remains.
                    if (r_count == 2'd2) begin
                        r_data0 <= r_data1;
                        r_last0 <= r_last1;
                        r_data1 <= i_push_data;
                        r_last1 <= i_push_last;
                    end else begin
                        r_data0 <= i_push_data;
                        r_last0 <= i_push_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_count = r_count;
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_data0;
    assign o_last  = r_last0;

endmodule

// File: rtl/mem_read_streamer.sv
// Read sequencer: walks a word range of a synchronous-read memory and
// streams the words out in address order over valid/ready.
module mem_read_streamer
    import nna_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [DEPTH-1:0] i_base_addr,
    input  logic [DEPTH:0]   i_length,
    output logic             o_busy,
    output logic             o_done,
    output logic [DEPTH-1:0] o_mem_read_addr,
    input  logic [WIDTH-1:0] i_mem_data,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_out_last
);

    localparam logic [DEPTH-1:0] ADDR_ONE = {{(DEPTH-1){1'b0}}, 1'b1};
    localparam logic [DEPTH:0]   CNT_ONE  = {{DEPTH{1'b0}}, 1'b1};
    localparam logic [2:0]       CREDITS  = 3'(STREAM_CREDITS);

    rd_state_t        r_state;
    rd_state_t        w_state_next;
    logic [DEPTH-1:0] r_addr;
    logic [DEPTH:0]   r_issue_cnt;
    logic             r_inflight;
    logic             r_inflight_last;

    logic [1:0]       w_fifo_count;
    logic             w_fifo_valid;
    logic             w_fifo_last;
    logic             w_pop;
    logic [2:0]       w_occupancy;
    logic             w_issue;
    logic             w_accept;

    // A pop this cycle frees a slot, so issue can resume as soon as ready rises.
    assign w_pop       = w_fifo_valid & i_out_ready;
    assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue     = (r_state == RUN) && (r_issue_cnt != '0) && (w_occupancy < CREDITS);
    assign w_accept    = (r_state == IDLE) && i_start && (i_length != '0);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b1;
        o_done       = 1'b0;
        case (r_state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_state_next = (i_length == '0) ? FINISH : RUN;
                end
            end
            RUN: begin
                if (w_pop && w_fifo_last) begin
                    w_state_next = FINISH;
                end
            end
            FINISH: begin
                o_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Address/issue counters and the one-cycle memory latency tracker.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr          <= '0;
            r_issue_cnt     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_issue_cnt == CNT_ONE);
            if (w_accept) begin
                r_addr      <= i_base_addr;
                r_issue_cnt <= i_length;
            end else if (w_issue) begin
                r_addr      <= r_addr + ADDR_ONE;
                r_issue_cnt <= r_issue_cnt - CNT_ONE;
            end
        end
    end

    stream_fifo2 #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (r_inflight),
        .i_push_data (i_mem_data),
        .i_push_last (r_inflight_last),
        .i_pop       (w_pop),
        .o_count     (w_fifo_count),
        .o_valid     (w_fifo_valid),
        .o_data      (o_out_data),
        .o_last      (w_fifo_last)
    );

    assign o_mem_read_addr = r_addr;
    assign o_out_valid     = w_fifo_valid;
    assign o_out_last      = w_fifo_last & w_fifo_valid;

endmodule

// File: tb/tb_mem_read_streamer.sv
// Scoreboard bench for mem_read_streamer with a behavioural memory model.
module tb_mem_read_streamer;

    localparam int DEPTH = 8;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             i_rst;
    logic             i_start;
    logic [DEPTH-1:0] i_base_addr;
    logic [DEPTH:0]   i_length;
    logic             o_busy;
    logic             o_done;
    logic [DEPTH-1:0] o_mem_read_addr;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] o_out_data;
    logic             o_out_valid;
    logic             i_out_ready;
    logic             o_out_last;

    always #5 clk = ~clk;

    mem_read_streamer #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .i_clk           (clk),
        .i_rst           (i_rst),
        .i_start         (i_start),
        .i_base_addr     (i_base_addr),
        .i_length        (i_length),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_mem_read_addr (o_mem_read_addr),
        .i_mem_data      (rd_data),
        .o_out_data      (o_out_data),
        .o_out_valid     (o_out_valid),
        .i_out_ready     (i_out_ready),
        .o_out_last      (o_out_last)
    );

    // Synchronous-read memory model.
    logic [WIDTH-1:0] mem [0:255];
    always @(posedge clk) rd_data <= mem[o_mem_read_addr];

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } word_t;
    word_t exp_q[$];

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    int done_exp = 0;
    int ready_mode = 0;
    int phase = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Consumer ready: 0 = always, 1 = repeating 1,0,0, 2 = random.
    always @(negedge clk) begin
        case (ready_mode)
            0: i_out_ready = 1'b1;
            1: begin
                i_out_ready = (phase % 3 == 0);
                phase++;
            end
            default: i_out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: scoreboard pops, hold-while-stalled and outstanding-read bound.
    logic             stall_prev = 1'b0;
    logic [WIDTH-1:0] prev_data;
    logic             prev_last;
    logic             prev_busy = 1'b0;
    logic [DEPTH-1:0] prev_addr;
    int               outstanding = 0;
    always begin
        @(negedge clk);
        #2;
        if (i_rst) begin
            stall_prev  = 1'b0;
            prev_busy   = 1'b0;
            outstanding = 0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 32'(o_out_valid), 1);
                check("hold_data", 32'(o_out_data), 32'(prev_data));
                check("hold_last", 32'(o_out_last), 32'(prev_last));
            end
            if (prev_busy && o_busy && (o_mem_read_addr == prev_addr + 8'd1)) outstanding++;
            if (o_busy) check("outstanding_le2", 32'(outstanding <= 2), 1);
            if (o_out_valid && i_out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%0h expected no word", o_out_data);
                end else begin
                    word_t e;
                    e = exp_q.pop_front();
                    check("data", 32'(o_out_data), 32'(e.data));
                    check("last", 32'(o_out_last), 32'(e.last));
                end
                outstanding--;
            end
            if (o_done) done_seen++;
            stall_prev = o_out_valid && !i_out_ready;
            prev_data  = o_out_data;
            prev_last  = o_out_last;
            prev_busy  = o_busy;
            prev_addr  = o_mem_read_addr;
        end
    end

    // Issue one command (accepted in cycle 0); returns at the cycle-1 negedge.
    task automatic start_cmd(input logic [7:0] base, input logic [8:0] len);
        @(negedge clk);
        i_start     = 1'b1;
        i_base_addr = base;
        i_length    = len;
        for (int k = 0; k < int'(len); k++) begin
            word_t w;
            w.data = mem[8'(int'(base) + k)];
            w.last = (k == int'(len) - 1);
            exp_q.push_back(w);
        end
        done_exp++;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit got;
        got = 1'b0;
        for (int c = 0; c < budget; c++) begin
            #2;
            if (o_done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({name, "_done"}, 32'(got), 1);
        if (got) begin
            @(negedge clk);
            #2;
            check({name, "_idle_after"}, 32'(o_busy), 0);
            check({name, "_queue_empty"}, exp_q.size(), 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        i_rst       = 1'b1;
        i_start     = 1'b0;
        i_base_addr = '0;
        i_length    = '0;
        i_out_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i + 'h100);
        repeat (3) @(negedge clk);
        #2;
        check("rst_busy", 32'(o_busy), 0);
        check("rst_done", 32'(o_done), 0);
        check("rst_valid", 32'(o_out_valid), 0);
        check("rst_last", 32'(o_out_last), 0);
        check("rst_data", 32'(o_out_data), 0);
        check("rst_addr", 32'(o_mem_read_addr), 0);
        @(negedge clk);
        i_rst = 1'b0;

        // Basic latency: words in cycles 3..5, done in cycle 6.
        start_cmd(8'd4, 9'd3);
        #2;
        check("basic_c1_busy", 32'(o_busy), 1);
        check("basic_c1_addr", 32'(o_mem_read_addr), 4);
        @(negedge clk);
        @(negedge clk);
        #2;
        check("basic_c3_valid", 32'(o_out_valid), 1);
        check("basic_c3_data", 32'(o_out_data), 'h104);
        check("basic_c3_last", 32'(o_out_last), 0);
        @(negedge clk);
        #2;
        check("basic_c4_data", 32'(o_out_data), 'h105);
        @(negedge clk);
        #2;
        check("basic_c5_data", 32'(o_out_data), 'h106);
        check("basic_c5_last", 32'(o_out_last), 1);
        @(negedge clk);
        #2;
        check("basic_c6_done", 32'(o_done), 1);
        @(negedge clk);
        #2;
        check("basic_c7_busy", 32'(o_busy), 0);
        check("basic_c7_done", 32'(o_done), 0);

        // Address wrap.
        start_cmd(8'hFE, 9'd4);
        wait_done("wrap", 50);

        // Backpressure 1,0,0 pattern.
        phase      = 0;
        ready_mode = 1;
        start_cmd(8'h10, 9'd8);
        wait_done("bp", 200);

        // Zero length.
        ready_mode = 0;
        start_cmd(8'h20, 9'd0);
        #2;
        check("zero_c1_done", 32'(o_done), 1);
        check("zero_c1_busy", 32'(o_busy), 1);
        check("zero_c1_valid", 32'(o_out_valid), 0);
        @(negedge clk);
        #2;
        check("zero_c2_done", 32'(o_done), 0);
        check("zero_c2_busy", 32'(o_busy), 0);
        check("zero_c2_valid", 32'(o_out_valid), 0);

        // Abort mid-command with reset in cycle 5.
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        start_cmd(8'h40, 9'd10);
        repeat (4) @(negedge clk);
        i_rst = 1'b1;
        exp_q.delete();
        done_exp--;
        @(negedge clk);
        i_rst = 1'b0;
        #2;
        check("abort_busy", 32'(o_busy), 0);
        check("abort_valid", 32'(o_out_valid), 0);
        check("abort_done", 32'(o_done), 0);
        check("abort_data", 32'(o_out_data), 0);
        check("abort_addr", 32'(o_mem_read_addr), 0);
        repeat (3) @(negedge clk);
        #2;
        check("abort_no_done", 32'(o_done), 0);
        start_cmd(8'h80, 9'd5);
        wait_done("after_abort", 50);

        // Random commands under random backpressure.
        ready_mode = 2;
        for (int n = 0; n < 6; n++) begin
            start_cmd(8'($urandom), 9'($urandom_range(1, 20)));
            wait_done("rand", 400);
        end

        // Full sweep with a start pulsed while busy.
        start_cmd(8'($urandom), 9'd256);
        repeat (20) @(negedge clk);
        i_start     = 1'b1;
        i_base_addr = 8'h33;
        i_length    = 9'd5;
        @(negedge clk);
        i_start = 1'b0;
        wait_done("sweep", 3000);

        @(negedge clk);
        #2;
        check("done_count", done_seen, done_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
